// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths, word types and the modular-exponentiation FSM state encoding.
//   WIDTH_DEF     : default modulus/operand width
//   EXP_WIDTH_DEF : default exponent width
package rsa_pkg;
    localparam int WIDTH_DEF     = 6;
    localparam int EXP_WIDTH_DEF = 6;

    typedef logic [WIDTH_DEF-1:0]     word_t;
    typedef logic [EXP_WIDTH_DEF-1:0] exp_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQ_GO,
        SQ_WAIT,
        MU_GO,
        MU_WAIT,
        NEXT,
        FIN
    } modexp_state_t;
endpackage

// File: rtl/mod_mul_interleaved.sv
// mod_mul_interleaved: p = a*b mod n, one multiplier bit per cycle, MSB first.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse; latches a, b, n (a < n required)
//   done       : one-cycle pulse W+1 cycles after start
//   p          : product, valid while done is high and held afterwards
module mod_mul_interleaved
    import rsa_pkg::*;
#(
    parameter int W = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  a_q, b_q, n_q, p_q;
    logic [KW-1:0] k_q;
    logic          run_q, done_q;
    logic [W:0]    nx, dbl, dbl_r, sum;
    logic [W-1:0]  p_d;

    // Both partial results stay below 2n, so one conditional subtract per stage suffices.
    always_comb begin
        nx    = {1'b0, n_q};
        dbl   = {p_q, 1'b0};
        dbl_r = (dbl >= nx) ? dbl - nx : dbl;
        sum   = dbl_r + (b_q[k_q] ? {1'b0, a_q} : '0);
        p_d   = W'((sum >= nx) ? sum - nx : sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            p_q    <= '0;
            k_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            p_q    <= '0;
            k_q    <= KW'(W - 1);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= run_q && (k_q == '0);
            if (run_q) begin
                p_q   <= p_d;
                k_q   <= k_q - 1'b1;
                run_q <= (k_q != '0);
            end
        end
    end

    assign done = done_q;
    assign p    = p_q;
endmodule

// File: rtl/mod_exp_sequencer.sv
// mod_exp_sequencer: constant-time left-to-right square-and-multiply, result = m^e mod n.
//   clk, reset         : clock, synchronous active-high reset
//   start, m, e, n     : request (sampled only in IDLE), base, exponent, modulus
//   busy, done, err    : in-progress flag, one-cycle completion pulse, n < 2 flag
//   result             : m^e mod n, held until overwritten by a later request
//   mm_start/a/b/n     : operand side of the modular multiplier handshake
//   mm_done, mm_p      : external product return; tie mm_done low to use the internal multiplier
module mod_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]     n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_n,
    input  logic                 mm_done,
    input  logic [WIDTH-1:0]     mm_p
);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    modexp_state_t        state_q, state_d;
    logic [WIDTH-1:0]     mr_q, mr_d, nr_q, nr_d, acc_q, acc_d, result_q, result_d;
    logic [WIDTH-1:0]     mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic [EXP_WIDTH-1:0] er_q, er_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                 int_done, mul_done;
    logic [WIDTH-1:0]     int_p, mul_p;

    assign mm_start = (state_q == SQ_GO) || (state_q == MU_GO);

    mod_mul_interleaved #(.W(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a_q),
        .b     (mm_b_q),
        .n     (nr_q),
        .done  (int_done),
        .p     (int_p)
    );

    // Either multiplier may answer; only the WAIT states listen, so stray pulses are dropped.
    assign mul_done = int_done | mm_done;
    assign mul_p    = int_done ? int_p : mm_p;

    always_comb begin
        state_d  = state_q;
        mr_d     = mr_q;
        er_d     = er_q;
        nr_d     = nr_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        case (state_q)
            IDLE: if (start) begin
                mr_d    = m;
                er_d    = e;
                nr_d    = n;
                busy_d  = 1'b1;
                state_d = LOAD;
            end
            LOAD: if (nr_q < WIDTH'(2)) begin
                result_d = '0;
                err_d    = 1'b1;
                state_d  = FIN;
            end else begin
                acc_d   = WIDTH'(1);
                idx_d   = IW'(EXP_WIDTH - 1);
                mm_a_d  = WIDTH'(1);
                mm_b_d  = WIDTH'(1);
                state_d = SQ_GO;
            end
            SQ_GO: state_d = SQ_WAIT;
            SQ_WAIT: if (mul_done) begin
                acc_d   = mul_p;
                mm_a_d  = mul_p;
                mm_b_d  = mr_q;
                state_d = MU_GO;
            end
            MU_GO: state_d = MU_WAIT;
            // The multiply always runs; a zero exponent bit just discards its product.
            MU_WAIT: if (mul_done) begin
                acc_d   = er_q[idx_q] ? mul_p : acc_q;
                state_d = NEXT;
            end
            NEXT: if (idx_q == '0) begin
                result_d = acc_q;
                err_d    = 1'b0;
                state_d  = FIN;
            end else begin
                idx_d   = idx_q - 1'b1;
                mm_a_d  = acc_q;
                mm_b_d  = acc_q;
                state_d = SQ_GO;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mr_q     <= '0;
            er_q     <= '0;
            nr_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            mr_q     <= mr_d;
            er_q     <= er_d;
            nr_q     <= nr_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign mm_a   = mm_a_q;
    assign mm_b   = mm_b_q;
    assign mm_n   = nr_q;
endmodule
